// File: rtl/sr04_sched.sv
// sr04_sched: four-channel ultrasonic ranging scheduler.
// Picks an enabled sensor (round-robin from a rotating pointer), fires its
// trigger pulse, times the echo high period and reports the count or a
// timeout, then holds off before the next measurement.
module sr04_sched #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int GAP_CYCLES     = 3_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic        START,
    input  logic [3:0]  EN,
    input  logic [3:0]  ECHO,
    output logic [3:0]  TRIG,
    output logic        BUSY,
    output logic        RESULT_VALID,
    output logic [1:0]  RESULT_CH,
    output logic [23:0] RESULT_CNT,
    output logic        RESULT_TIMEOUT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_REPORT,
        ST_GAP
    } state_t;

    localparam logic [23:0] TRIG_LAST = 24'(TRIG_CYCLES - 1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);
    localparam logic [23:0] CNT_MAX   = 24'hFFFFFF;

    state_t      state;
    logic [3:0]  echo_s1;
    logic [3:0]  echo_s2;
    logic [3:0]  echo_d;
    logic [1:0]  ptr;
    logic [1:0]  ch;
    logic [23:0] t_cnt;
    logic [23:0] e_cnt;
    logic [23:0] phase_cnt;
    logic [1:0]  ch_pick;
    logic [1:0]  idx;
    logic        echo_cur;
    logic        echo_rise;
    logic        echo_fall;

    // Edge detection on the selected channel uses only synchronized samples.
    assign echo_cur  = echo_s2[ch];
    assign echo_rise = echo_s2[ch] & ~echo_d[ch];
    assign echo_fall = ~echo_s2[ch] & echo_d[ch];

    // First enabled sensor at or after ptr, wrapping; lowest offset wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        ch_pick = ptr;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (EN[idx]) begin
                ch_pick = idx;
            end
        end
    end

    // Echo synchronizers, measurement FSM and registered outputs.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            state          <= ST_IDLE;
            echo_s1        <= '0;
            echo_s2        <= '0;
            echo_d         <= '0;
            ptr            <= '0;
            ch             <= '0;
            t_cnt          <= '0;
            e_cnt          <= '0;
            phase_cnt      <= '0;
            TRIG           <= '0;
            BUSY           <= 1'b0;
            RESULT_VALID   <= 1'b0;
            RESULT_CH      <= '0;
            RESULT_CNT     <= '0;
            RESULT_TIMEOUT <= 1'b0;
        end else begin
            echo_s1      <= ECHO;
            echo_s2      <= echo_s1;
            echo_d       <= echo_s2;
            RESULT_VALID <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if ((RUN || START) && (EN != 4'b0000)) begin
                        ch        <= ch_pick;
                        TRIG      <= 4'b0001 << ch_pick;
                        phase_cnt <= '0;
                        BUSY      <= 1'b1;
                        state     <= ST_TRIG;
                    end
                end

                ST_TRIG: begin
                    if (phase_cnt == TRIG_LAST) begin
                        TRIG  <= '0;
                        t_cnt <= '0;
                        state <= ST_WAIT_RISE;
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end

                ST_WAIT_RISE: begin
                    if (t_cnt == TO_LAST) begin
                        RESULT_VALID   <= 1'b1;
                        RESULT_CH      <= ch;
                        RESULT_CNT     <= CNT_MAX;
                        RESULT_TIMEOUT <= 1'b1;
                        state          <= ST_REPORT;
                    end else begin
                        t_cnt <= t_cnt + 24'd1;
                        if (echo_rise) begin
                            // The rise cycle is itself the first high cycle of the echo.
                            e_cnt <= 24'd1;
                            state <= ST_MEASURE;
                        end
                    end
                end

                ST_MEASURE: begin
                    // A fall in the timeout cycle still reports the real count.
                    if (echo_fall) begin
                        RESULT_VALID   <= 1'b1;
                        RESULT_CH      <= ch;
                        RESULT_CNT     <= e_cnt;
                        RESULT_TIMEOUT <= 1'b0;
                        state          <= ST_REPORT;
                    end else if (t_cnt == TO_LAST) begin
                        RESULT_VALID   <= 1'b1;
                        RESULT_CH      <= ch;
                        RESULT_CNT     <= CNT_MAX;
                        RESULT_TIMEOUT <= 1'b1;
                        state          <= ST_REPORT;
                    end else begin
                        t_cnt <= t_cnt + 24'd1;
                        if (echo_cur && (e_cnt != CNT_MAX)) begin
                            e_cnt <= e_cnt + 24'd1;
                        end
                    end
                end

                ST_REPORT: begin
                    ptr       <= ch + 2'd1;
                    phase_cnt <= '0;
                    state     <= ST_GAP;
                end

                ST_GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end

                default: begin
                    TRIG  <= '0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_sched.sv
// tb_sr04_sched: directed and randomized checks of sr04_sched against a
// transaction-level model (round-robin pick, echo length, timeout).
module tb_sr04_sched;

    localparam int TRIG_CYC = 4;
    localparam int TO_CYC   = 100;
    localparam int GAP_CYC  = 10;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b1;
    logic        RUN   = 1'b0;
    logic        START = 1'b0;
    logic [3:0]  EN    = 4'b0000;
    logic [3:0]  ECHO  = 4'b0000;
    logic [3:0]  TRIG;
    logic        BUSY;
    logic        RESULT_VALID;
    logic [1:0]  RESULT_CH;
    logic [23:0] RESULT_CNT;
    logic        RESULT_TIMEOUT;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int ptr_m     = 0;
    int have_prev = 0;
    int last_fall = 0;

    sr04_sched #(
        .TRIG_CYCLES   (TRIG_CYC),
        .TIMEOUT_CYCLES(TO_CYC),
        .GAP_CYCLES    (GAP_CYC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RUN           (RUN),
        .START         (START),
        .EN            (EN),
        .ECHO          (ECHO),
        .TRIG          (TRIG),
        .BUSY          (BUSY),
        .RESULT_VALID  (RESULT_VALID),
        .RESULT_CH     (RESULT_CH),
        .RESULT_CNT    (RESULT_CNT),
        .RESULT_TIMEOUT(RESULT_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (RESULT_VALID === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first enabled sensor searching upward from p, wrapping.
    function automatic int pick(input logic [3:0] en, input int p);
        for (int k = 0; k < 4; k++) begin
            if (en[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic start_pulse;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (BUSY === 1'b0) found = 1;
            else tick();
        end
        check({tag, " idle"}, 32'(found), 32'd1);
    endtask

    // One measurement: trigger expected on the model's pick; echo of n cycles
    // starting d cycles after the trigger ends (n == 0 means no echo).
    task automatic measure(input string tag, input logic [3:0] en_sel, input logic [3:0] en_mid,
                           input bit drop_run, input int d, input int n);
        int         exp_ch;
        int         w;
        bit         found;
        logic [3:0] oh;
        exp_ch = pick(en_sel, ptr_m);
        oh     = 4'b0001 << exp_ch;
        found  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (TRIG !== 4'b0000) found = 1;
            else tick();
        end
        check({tag, " trig_seen"}, 32'(found), 32'd1);
        if (!found) return;
        if (have_prev != 0) check({tag, " gap"}, 32'((cyc - last_fall) >= GAP_CYC), 32'd1);
        check({tag, " trig_ch"}, 32'(TRIG), 32'(oh));
        EN = en_mid;
        if (drop_run) RUN = 1'b0;
        w = 0;
        while (TRIG !== 4'b0000 && w < 50) begin
            w++;
            tick();
        end
        check({tag, " trig_width"}, 32'(w), 32'(TRIG_CYC));
        last_fall = cyc;
        have_prev = 1;
        repeat (d) tick();
        if (n > 0) begin
            ECHO = (4'($urandom) & ~oh) | oh;
            repeat (n) begin
                tick();
                ECHO = (4'($urandom) & ~oh) | oh;
            end
            ECHO = 4'b0000;
        end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (RESULT_VALID === 1'b1) found = 1;
            else tick();
        end
        check({tag, " result_seen"}, 32'(found), 32'd1);
        if (!found) return;
        check({tag, " result_ch"}, 32'(RESULT_CH), 32'(exp_ch));
        check({tag, " result_cnt"}, 32'(RESULT_CNT), (n > 0) ? 32'(n) : 32'hFFFFFF);
        check({tag, " result_to"}, 32'(RESULT_TIMEOUT), (n > 0) ? 32'd0 : 32'd1);
        tick();
        check({tag, " valid_pulse"}, 32'(RESULT_VALID), 32'd0);
        tick();
        check({tag, " cnt_hold"}, 32'(RESULT_CNT), (n > 0) ? 32'(n) : 32'hFFFFFF);
        ptr_m = (exp_ch + 1) % 4;
    endtask

    initial begin
        int         v0;
        bit         bad;
        logic [3:0] en_r;
        logic [3:0] en_m;
        int         d_r;
        int         n_r;

        // Reset state
        repeat (3) tick();
        check("rst trig", 32'(TRIG), 32'd0);
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst valid", 32'(RESULT_VALID), 32'd0);
        check("rst ch", 32'(RESULT_CH), 32'd0);
        check("rst cnt", 32'(RESULT_CNT), 32'd0);
        check("rst to", 32'(RESULT_TIMEOUT), 32'd0);
        RST = 1'b0;
        tick();

        // Single START measurement, echo 20 cycles
        EN = 4'b0001;
        start_pulse();
        measure("single", 4'b0001, 4'b0001, 1'b0, 5, 20);
        wait_idle("single");

        // No echo: timeout on sensor 2
        EN = 4'b0100;
        start_pulse();
        measure("timeout", 4'b0100, 4'b0100, 1'b0, 0, 0);
        wait_idle("timeout");

        // EN cleared mid-measurement, START while BUSY ignored
        v0 = valid_cnt;
        EN = 4'b0011;
        start_pulse();
        measure("busy_start", 4'b0011, 4'b0000, 1'b0, 3, 9);
        check("busy_start busy_in_gap", 32'(BUSY), 32'd1);
        EN = 4'b0011;
        start_pulse();
        wait_idle("busy_start");
        repeat (30) tick();
        check("busy_start not_queued", 32'(BUSY), 32'd0);
        check("busy_start one_valid", 32'(valid_cnt - v0), 32'd1);

        // Reset during TRIG aborts; pointer returns to 0
        EN = 4'b1111;
        start_pulse();
        check("abort trig_ch", 32'(TRIG), 32'(4'b0001 << pick(4'b1111, ptr_m)));
        tick();
        RST = 1'b1;
        tick();
        check("abort trig_off", 32'(TRIG), 32'd0);
        check("abort busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        v0 = valid_cnt;
        repeat (150) tick();
        check("abort no_valid", 32'(valid_cnt - v0), 32'd0);
        ptr_m     = 0;
        have_prev = 0;
        start_pulse();
        measure("after_rst", 4'b1111, 4'b1111, 1'b0, 2, 6);
        wait_idle("after_rst");

        // RUN round-robin on sensors 1 and 3; RUN drops during the 4th
        EN  = 4'b1010;
        RUN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            measure($sformatf("rr%0d", k), 4'b1010, 4'b1010, (k == 3), 4, 7);
        end
        wait_idle("rr");
        repeat (40) tick();
        check("rr stopped trig", 32'(TRIG), 32'd0);
        check("rr stopped busy", 32'(BUSY), 32'd0);

        // EN = 0 with RUN stays idle
        EN  = 4'b0000;
        RUN = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (BUSY !== 1'b0 || TRIG !== 4'b0000) bad = 1;
        end
        check("en0 idle", 32'(bad), 32'd0);
        RUN = 1'b0;

        // Randomized START measurements with EN changes mid-flight
        for (int r = 0; r < 10; r++) begin
            en_r = 4'($urandom_range(1, 15));
            en_m = 4'($urandom);
            d_r  = $urandom_range(0, 20);
            n_r  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
            EN   = en_r;
            start_pulse();
            measure($sformatf("rand%0d", r), en_r, en_m, 1'b0, d_r, n_r);
            wait_idle($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
